// File: rtl/exec_sequencer.sv
// Four-state instruction sequencer: IDLE -> EXEC -> WB/BRANCH -> IDLE.
// Strobes decode from the registered state and latched instruction fields.
module exec_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [1:0]  instr_kind,
  input  logic [2:0]  cond,
  input  logic        flag_z,
  input  logic        flag_n,
  input  logic        flag_c,
  input  logic        flag_v,
  input  logic        flush,
  output logic        alu_en,
  output logic        reg_write,
  output logic        flags_write,
  output logic        pc_load,
  output logic        pc_inc,
  output logic        done,
  output logic [15:0] instr_count,
  output logic [15:0] taken_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_WB     = 2'd2;
  localparam logic [1:0] S_BRANCH = 2'd3;

  localparam logic [1:0] K_ALU  = 2'b00;
  localparam logic [1:0] K_CMP  = 2'b01;
  localparam logic [1:0] K_JUMP = 2'b10;
  localparam logic [1:0] K_MOV  = 2'b11;

  logic [1:0]  r_state;
  logic [1:0]  r_kind;
  logic [2:0]  r_cond;
  logic        r_taken;
  logic [15:0] r_instr_count;
  logic [15:0] r_taken_count;

  logic [1:0]  w_next;
  logic        w_taken;
  logic        w_idle;
  logic        w_exec;
  logic        w_wb;
  logic        w_branch;
  logic        w_unused_v;

  // Overflow flag takes no part in any condition code.
  assign w_unused_v = flag_v;

  assign w_idle   = (r_state == S_IDLE);
  assign w_exec   = (r_state == S_EXEC);
  assign w_wb     = (r_state == S_WB);
  assign w_branch = (r_state == S_BRANCH);

  always_comb begin
    w_taken = 1'b0;
    unique case (r_cond)
      3'b000: w_taken = 1'b1;
      3'b001: w_taken = flag_z;
      3'b010: w_taken = !flag_z;
      3'b011: w_taken = !flag_z && !flag_n;
      3'b100: w_taken = !flag_n;
      3'b101: w_taken = flag_n;
      3'b110: w_taken = flag_z || flag_n;
      3'b111: w_taken = flag_c;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      w_idle:   w_next = instr_valid ? S_EXEC : S_IDLE;
      w_exec: begin
        if (flush)
          w_next = S_IDLE;
        else if (r_kind == K_JUMP)
          w_next = S_BRANCH;
        else
          w_next = S_WB;
      end
      w_wb:     w_next = S_IDLE;
      w_branch: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_kind  <= 2'b00;
      r_cond  <= 3'b000;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_idle && instr_valid) begin
        r_kind <= instr_kind;
        r_cond <= cond;
      end
      if (w_exec && r_kind == K_JUMP)
        r_taken <= w_taken;
    end
  end

  // Retire counter wraps; taken counter saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_count <= 16'h0000;
      r_taken_count <= 16'h0000;
    end else begin
      if (w_wb || w_branch)
        r_instr_count <= r_instr_count + 16'd1;
      if (w_branch && r_taken && r_taken_count != 16'hFFFF)
        r_taken_count <= r_taken_count + 16'd1;
    end
  end

  assign instr_ready = w_idle;
  assign alu_en      = w_exec && (r_kind != K_JUMP);
  assign reg_write   = w_wb && (r_kind == K_ALU || r_kind == K_MOV);
  assign flags_write = w_wb && (r_kind == K_ALU || r_kind == K_CMP);
  assign pc_load     = w_branch && r_taken;
  assign pc_inc      = w_wb || (w_branch && !r_taken);
  assign done        = w_wb || w_branch;
  assign instr_count = r_instr_count;
  assign taken_count = r_taken_count;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed and randomized bench for exec_sequencer with a
// per-instruction reference model of strobes and counters.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  instr_kind;
  logic [2:0]  cond;
  logic        flag_z, flag_n, flag_c, flag_v;
  logic        flush;
  logic        alu_en, reg_write, flags_write;
  logic        pc_load, pc_inc, done;
  logic [15:0] instr_count, taken_count;

  int n_vec = 0;
  int n_err = 0;
  int m_icount = 0;
  int m_tcount = 0;

  localparam int M_NORMAL = 0;
  localparam int M_FLUSH  = 1;
  localparam int M_RST    = 2;

  always #5 clk = ~clk;

  exec_sequencer dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_kind(instr_kind), .cond(cond),
    .flag_z(flag_z), .flag_n(flag_n),
    .flag_c(flag_c), .flag_v(flag_v),
    .flush(flush), .alu_en(alu_en),
    .reg_write(reg_write), .flags_write(flags_write),
    .pc_load(pc_load), .pc_inc(pc_inc), .done(done),
    .instr_count(instr_count), .taken_count(taken_count)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks the seven control outputs as one packed vector.
  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    chk(tag, {9'd0, instr_ready, alu_en, reg_write, flags_write,
              pc_load, pc_inc, done}, {9'd0, exp});
  endtask

  function automatic bit model_taken(input logic [2:0] c,
                                     input logic [3:0] f);
    bit z, n, cy;
    z = f[3]; n = f[2]; cy = f[1];
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return !z && !n;
      3'd4: return !n;
      3'd5: return n;
      3'd6: return z || n;
      default: return cy;
    endcase
  endfunction

  task automatic chk_counts(input string tag);
    chk({tag, "_icnt"}, instr_count, 16'(m_icount));
    chk({tag, "_tcnt"}, taken_count, 16'(m_tcount));
  endtask

  // One instruction from IDLE back to IDLE; f = {Z,N,C,V}.
  task automatic do_instr(input logic [1:0] k, input logic [2:0] c,
                          input logic [3:0] f, input int mode,
                          input string tag);
    bit is_jmp, tk;
    bit [6:0] exp;
    is_jmp = (k == 2'b10);
    tk = is_jmp && model_taken(c, f);
    @(negedge clk);
    chk_ctl({tag, "_idle"}, 7'b1000000);
    chk_counts(tag);
    instr_valid = 1'b1;
    instr_kind = k;
    cond = c;
    @(negedge clk);
    chk_ctl({tag, "_exec"}, {1'b0, !is_jmp, 5'b00000});
    instr_valid = 1'($urandom_range(0, 1));
    instr_kind = 2'($urandom);
    cond = 3'($urandom);
    {flag_z, flag_n, flag_c, flag_v} = f;
    flush = (mode == M_FLUSH);
    @(negedge clk);
    flush = 1'b0;
    instr_valid = 1'b0;
    if (mode == M_FLUSH) begin
      chk_ctl({tag, "_flushed"}, 7'b1000000);
      chk_counts({tag, "_flushed"});
      return;
    end
    if (is_jmp)
      exp = {3'b000, 1'b0, tk, !tk, 1'b1};
    else
      exp = {3'b000, (k == 2'b00 || k == 2'b11),
             (k == 2'b00 || k == 2'b01), 1'b0, 1'b1, 1'b1};
    chk_ctl({tag, "_retire"}, exp);
    if (mode == M_RST) begin
      rst = 1'b1;
      flush = 1'b1;
      instr_valid = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      flush = 1'b0;
      instr_valid = 1'b0;
      m_icount = 0;
      m_tcount = 0;
      chk_ctl({tag, "_rst"}, 7'b1000000);
      chk_counts({tag, "_rst"});
      return;
    end
    flush = 1'($urandom_range(0, 1));
    m_icount = (m_icount + 1) % 65536;
    if (tk && m_tcount < 65535)
      m_tcount = m_tcount + 1;
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr_kind = 2'b00;
    cond = 3'b000;
    {flag_z, flag_n, flag_c, flag_v} = 4'b0000;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_ctl("reset_ctl", 7'b1000000);
    chk_counts("reset");

    do_instr(2'b00, 3'd0, 4'b0000, M_NORMAL, "alu");
    do_instr(2'b01, 3'd0, 4'b0000, M_NORMAL, "cmp");
    do_instr(2'b10, 3'd1, 4'b1000, M_NORMAL, "jeq_t");
    do_instr(2'b01, 3'd0, 4'b0000, M_NORMAL, "cmp2");
    do_instr(2'b10, 3'd1, 4'b0000, M_NORMAL, "jeq_nt");
    do_instr(2'b11, 3'd0, 4'b0000, M_FLUSH, "mov_flush");
    do_instr(2'b11, 3'd0, 4'b0000, M_NORMAL, "mov");

    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 16; f++)
        do_instr(2'b10, 3'(c), 4'(f), M_NORMAL, "sweep");

    for (int i = 0; i < 200; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      do_instr(2'($urandom), 3'($urandom), 4'($urandom),
               (r == 0) ? M_FLUSH : M_NORMAL, "rand");
    end

    @(negedge clk);
    force dut.r_instr_count = 16'hFFFF;
    force dut.r_taken_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_instr_count;
    release dut.r_taken_count;
    m_icount = 65535;
    m_tcount = 65535;
    do_instr(2'b10, 3'd0, 4'b0000, M_NORMAL, "wrap");
    do_instr(2'b10, 3'd0, 4'b0000, M_NORMAL, "sat");

    do_instr(2'b00, 3'd0, 4'b0000, M_RST, "alu_rst");
    do_instr(2'b00, 3'd0, 4'b0000, M_NORMAL, "after_rst");
    @(negedge clk);
    chk_counts("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 instr_valid  input  1  instruction offered this cycle.
REQ-005 instr_ready  output  1  sequencer can accept an instruction.
REQ-006 instr_kind  input  2  00 ALU (reg + flags), 01 CMP (flags only), 10 JUMP, 11 MOV (reg only).
REQ-007 cond  input  3  jump condition; used only when instr_kind=10.
REQ-008 flag_z, flag_n, flag_c, flag_v  input  1 each  current status-register flags.
REQ-009 flush  input  1  abort the in-flight instruction.
REQ-010 alu_en  output  1  datapath captures operands / ALU evaluates.
REQ-011 reg_write  output  1  register-file write strobe.
REQ-012 flags_write  output  1  status-register update strobe.
REQ-013 pc_load  output  1  load PC with the jump target.
REQ-014 pc_inc  output  1  increment PC.
REQ-015 done  output  1  one-cycle retire pulse.
REQ-016 instr_count  output  16  retired-instruction counter.
REQ-017 taken_count  output  16  taken-jump counter.

Function
REQ-018 FSM states SHALL be IDLE, EXEC, WB and BRANCH; all strobes SHALL be decoded from the registered state and latched fields only.
REQ-019 IDLE: instr_ready=1, all strobes 0; on instr_valid=1, kind_q<=instr_kind and cond_q<=cond, go to EXEC; otherwise stay in IDLE.
REQ-020 instr_ready SHALL be 0 in EXEC, WB and BRANCH; instr_valid outside IDLE SHALL be ignored.
REQ-021 EXEC: alu_en=1 for kinds ALU, CMP and MOV, alu_en=0 for JUMP; next state SHALL be BRANCH for JUMP, else WB.
REQ-022 EXEC for JUMP: taken_q SHALL be computed from the flags sampled this cycle: 000 always; 001 Z; 010 !Z; 011 !Z&!N; 100 !N; 101 N; 110 Z|N; 111 C.
REQ-023 WB: reg_write=1 for ALU and MOV; flags_write=1 for ALU and CMP; pc_inc=1; done=1; next state IDLE.
REQ-024 BRANCH: pc_load=taken_q, pc_inc=!taken_q, done=1; next state IDLE.
REQ-025 Latency: accept in cycle T, EXEC in T+1, WB/BRANCH in T+2; the next accept is at T+3 at the earliest; throughput is 1 instruction per 3 cycles.
REQ-026 Because flags are written at the end of WB, a JUMP accepted immediately afterwards SHALL see the updated flags in its EXEC cycle; no extra stall is required.
REQ-027 flush=1 in EXEC SHALL return the FSM to IDLE at the next edge with no WB/BRANCH strobes, no done, and no counter change.
REQ-028 flush in IDLE, WB or BRANCH SHALL have no effect; that cycle's strobes and done SHALL still occur.
REQ-029 instr_count SHALL increment by 1 on every done and wrap from FFFF to 0000.
REQ-030 taken_count SHALL increment by 1 on BRANCH with taken_q=1 and saturate at FFFF.
REQ-031 flag_v SHALL be ignored by every condition code.

Reset
REQ-032 rst=1 at a rising edge SHALL force IDLE, kind_q=0, cond_q=0, taken_q=0, instr_count=0 and taken_count=0, regardless of state.
REQ-033 In the cycle after reset, alu_en, reg_write, flags_write, pc_load, pc_inc and done SHALL be 0 and instr_ready SHALL be 1.
REQ-034 rst asserted in EXEC, WB or BRANCH SHALL drop the instruction with no further strobes; rst SHALL take priority over flush and instr_valid.

Verification
REQ-035 ALU: accept kind=00 -> alu_en at T+1; reg_write, flags_write, pc_inc and done at T+2; instr_count 0->1.
REQ-036 CMP then JEQ: CMP accepted with flag_z driven 1 after WB; JUMP cond=001 -> BRANCH pc_load=1, pc_inc=0, taken_count=1. Repeat with flag_z=0 -> pc_inc=1, pc_load=0.
REQ-037 Condition sweep: all 8 cond values x 16 combinations of {Z,N,C,V} -> pc_load matches REQ-022, and V never changes the result.
REQ-038 Flush: MOV accepted, flush=1 in EXEC -> no reg_write, no done, instr_count unchanged, instr_ready=1 the next cycle.
REQ-039 Counters: preload instr_count=FFFF and taken_count=FFFF via forced state, retire a taken JMP -> instr_count=0000, taken_count stays FFFF.
REQ-040 Reset mid-op: rst in WB of an ALU op -> no strobes the next cycle, all counters 0, state IDLE.
